// File: rtl/pipe_hazard_ctrl_if.sv
// D-stage decode fields into the hazard controller, stall/bubble controls and perf counters out.
// The pipeline side drives through master; the controller consumes through slave.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             d_valid;
    logic [3:0]       d_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       d_dstM;
    logic             e_cnd;
    logic             f_stall;
    logic             d_stall;
    logic             d_bubble;
    logic             e_bubble;
    logic             ret_pending;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output d_valid, d_icode, d_srcA, d_srcB, d_dstM, e_cnd,
        input  f_stall, d_stall, d_bubble, e_bubble, ret_pending, stall_cnt, bubble_cnt
    );

    modport slave (
        input  d_valid, d_icode, d_srcA, d_srcB, d_dstM, e_cnd,
        output f_stall, d_stall, d_bubble, e_bubble, ret_pending, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 PIPE hazard controller: shadows the E/M/W instructions and drives F/D/E stall and
// bubble controls for load/use, ret draining and not-taken conditional jumps.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    typedef struct packed {
        logic       v;
        logic [3:0] icode;
        logic [3:0] dstm;
    } slot_t;

    localparam slot_t SLOT_NOP = '{v: 1'b0, icode: I_NOP, dstm: R_NONE};

    slot_t            se_q, sm_q, sw_q, se_d;
    logic             lu, ret, mp;
    logic             f_stall, d_stall, d_bubble, e_bubble;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Hazard terms; rst_n gating keeps every control low while reset is held.
    always_comb begin
        lu = 1'b0;
        ret = 1'b0;
        mp = 1'b0;
        if (rst_n) begin
            lu = se_q.v && hz.d_valid
                 && (se_q.icode == I_MRMOVQ || se_q.icode == I_POPQ)
                 && (se_q.dstm != R_NONE)
                 && (se_q.dstm == hz.d_srcA || se_q.dstm == hz.d_srcB);
            ret = (hz.d_valid && hz.d_icode == I_RET)
                  || (se_q.v && se_q.icode == I_RET)
                  || (sm_q.v && sm_q.icode == I_RET);
            mp = se_q.v && (se_q.icode == I_JXX) && !hz.e_cnd;
        end
    end

    // A load ahead of a ret wins: D holds rather than taking the ret bubble.
    always_comb begin
        f_stall  = lu | ret;
        d_stall  = lu;
        d_bubble = mp | (ret & ~lu);
        e_bubble = mp | lu;
    end

    always_comb begin
        se_d = SLOT_NOP;
        if (!e_bubble) begin
            se_d = '{v: hz.d_valid, icode: hz.d_icode, dstm: hz.d_dstM};
        end
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (f_stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((d_bubble || e_bubble) && bubble_cnt_q != '1) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            se_q         <= SLOT_NOP;
            sm_q         <= SLOT_NOP;
            sw_q         <= SLOT_NOP;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            sw_q         <= sm_q;
            sm_q         <= se_q;
            se_q         <= se_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign hz.f_stall     = f_stall;
    assign hz.d_stall     = d_stall;
    assign hz.d_bubble    = d_bubble;
    assign hz.e_bubble    = e_bubble;
    assign hz.ret_pending = ret;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.bubble_cnt  = bubble_cnt_q;

`ifndef SYNTHESIS
    // SW is diagnostic only: it must be last cycle's SM, and a ret reaching it must have drained.
    slot_t sm_last_q;
    logic  ret_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sm_last_q  <= SLOT_NOP;
            ret_last_q <= 1'b0;
        end else begin
            sm_last_q  <= sm_q;
            ret_last_q <= ret;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(lu && mp));
            assert (sw_q == sm_last_q);
            assert (!(sw_q.v && sw_q.icode == I_RET) || ret_last_q);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus randomized D-stage
// traffic compared against an in-flight instruction history model.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       v;
        logic [3:0] ic;
        logic [3:0] dm;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz();

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    logic [4:0] ctrl;
    assign ctrl = {hz.f_stall, hz.d_stall, hz.d_bubble, hz.e_bubble, hz.ret_pending};

    // flight[0] is the instruction in E, flight[1] in M, flight[2] in W.
    ent_t flight[$];
    int   exp_stall = 0;
    int   exp_bubble = 0;
    logic exp_f, exp_ds, exp_db, exp_eb, exp_ret;
    logic       cur_dv;
    logic [3:0] cur_ic, cur_dm;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic ent_t stage(input int k);
        ent_t e;
        e = '{v: 1'b0, ic: 4'h1, dm: 4'hF};
        if (flight.size() > k) e = flight[k];
        return e;
    endfunction

    task automatic model_eval(input logic dv, input logic [3:0] ic, sa, sb, input logic cnd);
        ent_t ex, mem;
        logic load_use, ret_any, mispred;
        ex = stage(0);
        mem = stage(1);
        load_use = ex.v && dv && (ex.ic == 4'h5 || ex.ic == 4'hB) && ex.dm != 4'hF
                   && (ex.dm == sa || ex.dm == sb);
        ret_any = (dv && ic == 4'h9) || (ex.v && ex.ic == 4'h9) || (mem.v && mem.ic == 4'h9);
        mispred = ex.v && ex.ic == 4'h7 && !cnd;
        exp_f = load_use || ret_any;
        exp_ds = load_use;
        exp_db = mispred || (ret_any && !load_use);
        exp_eb = mispred || load_use;
        exp_ret = ret_any;
    endtask

    task automatic drive(input logic dv, input logic [3:0] ic, sa, sb, dm, input logic cnd);
        hz.d_valid = dv;
        hz.d_icode = ic;
        hz.d_srcA = sa;
        hz.d_srcB = sb;
        hz.d_dstM = dm;
        hz.e_cnd = cnd;
        cur_dv = dv;
        cur_ic = ic;
        cur_dm = dm;
        #1;
        model_eval(dv, ic, sa, sb, cnd);
        check_val("f_stall", 32'(hz.f_stall), 32'(exp_f));
        check_val("d_stall", 32'(hz.d_stall), 32'(exp_ds));
        check_val("d_bubble", 32'(hz.d_bubble), 32'(exp_db));
        check_val("e_bubble", 32'(hz.e_bubble), 32'(exp_eb));
        check_val("ret_pending", 32'(hz.ret_pending), 32'(exp_ret));
        check_val("stall_cnt", 32'(hz.stall_cnt), 32'(exp_stall));
        check_val("bubble_cnt", 32'(hz.bubble_cnt), 32'(exp_bubble));
    endtask

    task automatic tick();
        @(posedge clk);
        if (exp_eb) flight.push_front('{v: 1'b0, ic: 4'h1, dm: 4'hF});
        else        flight.push_front('{v: cur_dv, ic: cur_ic, dm: cur_dm});
        if (flight.size() > 3) void'(flight.pop_back());
        if (exp_f && exp_stall < CNT_MAX) exp_stall++;
        if ((exp_db || exp_eb) && exp_bubble < CNT_MAX) exp_bubble++;
        @(negedge clk);
    endtask

    // Reset with a ret presented in D: all controls and counters must read 0 at once.
    task automatic do_reset();
        hz.d_valid = 1'b1;
        hz.d_icode = 4'h9;
        hz.d_srcA = 4'h3;
        hz.d_srcB = 4'h3;
        hz.d_dstM = 4'hF;
        hz.e_cnd = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("rst_ctrl", 32'(ctrl), 32'h0);
        check_val("rst_stall_cnt", 32'(hz.stall_cnt), 32'h0);
        check_val("rst_bubble_cnt", 32'(hz.bubble_cnt), 32'h0);
        flight.delete();
        exp_stall = 0;
        exp_bubble = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] rnd_reg();
        int r;
        r = $urandom_range(0, 5);
        return (r == 5) ? 4'hF : 4'(r);
    endfunction

    logic [3:0] ic_tbl [8] = '{4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h3};

    initial begin
        hz.d_valid = 1'b0;
        hz.d_icode = 4'h1;
        hz.d_srcA = 4'hF;
        hz.d_srcB = 4'hF;
        hz.d_dstM = 4'hF;
        hz.e_cnd = 1'b0;
        do_reset();

        // load/use: mrmovq -> %r3 followed by addq reading %r3
        drive(1'b1, 4'h5, 4'hF, 4'hF, 4'h3, 1'b0);
        tick();
        drive(1'b1, 4'h6, 4'h3, 4'hF, 4'hF, 1'b0);
        check_val("lu_ctrl", 32'(ctrl), 32'b11010);
        tick();
        drive(1'b1, 4'h6, 4'h3, 4'hF, 4'hF, 1'b0);
        check_val("lu_after_ctrl", 32'(ctrl), 32'h0);
        check_val("lu_stall_cnt", 32'(hz.stall_cnt), 32'd1);
        tick();

        // ret drain
        do_reset();
        drive(1'b1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b0);
        check_val("ret_c0", 32'(ctrl), 32'b10101);
        tick();
        for (int i = 1; i < 3; i++) begin
            drive(1'b0, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0);
            check_val($sformatf("ret_c%0d", i), 32'(ctrl), 32'b10101);
            tick();
        end
        drive(1'b0, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0);
        check_val("ret_done_ctrl", 32'(ctrl), 32'h0);
        check_val("ret_stall_cnt", 32'(hz.stall_cnt), 32'd3);
        check_val("ret_bubble_cnt", 32'(hz.bubble_cnt), 32'd3);
        tick();

        // mispredicted jne, then the taken variant
        do_reset();
        drive(1'b1, 4'h7, 4'hF, 4'hF, 4'hF, 1'b0);
        tick();
        drive(1'b1, 4'h6, 4'h1, 4'h2, 4'hF, 1'b0);
        check_val("mp_ctrl", 32'(ctrl), 32'b00110);
        tick();
        drive(1'b1, 4'h6, 4'h1, 4'h2, 4'hF, 1'b0);
        check_val("mp_after_ctrl", 32'(ctrl), 32'h0);
        tick();
        do_reset();
        drive(1'b1, 4'h7, 4'hF, 4'hF, 4'hF, 1'b1);
        tick();
        drive(1'b1, 4'h6, 4'h1, 4'h2, 4'hF, 1'b1);
        check_val("taken_ctrl", 32'(ctrl), 32'h0);
        tick();

        // popq -> %r4 in E with a ret reading %r4 in D
        do_reset();
        drive(1'b1, 4'hB, 4'hF, 4'hF, 4'h4, 1'b0);
        tick();
        drive(1'b1, 4'h9, 4'h4, 4'hF, 4'hF, 1'b0);
        check_val("lu_ret_ctrl", 32'(ctrl), 32'b11011);
        tick();
        drive(1'b1, 4'h9, 4'h4, 4'hF, 4'hF, 1'b0);
        check_val("lu_ret_next", 32'(ctrl), 32'b10101);
        tick();

        // load with no destination never stalls an instruction with no source
        do_reset();
        drive(1'b1, 4'h5, 4'hF, 4'hF, 4'hF, 1'b0);
        tick();
        drive(1'b1, 4'h6, 4'hF, 4'h2, 4'hF, 1'b0);
        check_val("noreg_ctrl", 32'(ctrl), 32'h0);
        tick();

        // counter saturation, then asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b0);
            tick();
        end
        drive(1'b1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b0);
        check_val("sat_stall_cnt", 32'(hz.stall_cnt), 32'd15);
        check_val("sat_bubble_cnt", 32'(hz.bubble_cnt), 32'd15);
        #1;
        do_reset();

        // randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                drive(($urandom_range(0, 7) != 0), ic_tbl[$urandom_range(0, 7)],
                      rnd_reg(), rnd_reg(), rnd_reg(), 1'($urandom_range(0, 1)));
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the PIPE Y86-64 core. It sits beside the decode/write-back stage and keeps a shadow record of the instructions in flight in E, M and W. From that record and the current D-stage register IDs it drives the stall and bubble controls for the F, D and E pipeline registers. It covers load/use hazards, `ret` draining and mispredicted conditional jumps, and keeps saturating counters of stall and bubble cycles.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall and bubble performance counters.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `d_valid`  in  1  D stage holds a real instruction (0 = bubble or empty).
- `d_icode`  in  4  icode of the instruction in D.
- `d_srcA`, `d_srcB`  in  4 each  source register IDs from decode; 4'hF means none.
- `d_dstM`  in  4  memory-destination register ID from decode; 4'hF means none.
- `e_cnd`  in  1  branch condition computed in E for the instruction held there.
- `f_stall`  out  1  hold the F (PC) register.
- `d_stall`  out  1  hold the D register.
- `d_bubble`  out  1  load a nop into D.
- `e_bubble`  out  1  load a nop into E.
- `ret_pending`  out  1  a `ret` is in D, E or M.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `f_stall`=1.
- `bubble_cnt`  out  CNT_W  saturating count of cycles with `d_bubble`=1 or `e_bubble`=1.

## Operation
Shadow slots:
- There are three slots: SE, SM and SW. Each holds {valid, icode[3:0], dstM[3:0]}.
- Every clock, the slots shift: SW<=SM and SM<=SE.
- SE is loaded as follows:
  - If `e_bubble`=1: SE<={0, 4'h1, 4'hF} (nop).
  - Otherwise: SE<={`d_valid`, `d_icode`, `d_dstM`}.
- There is no hold condition; E, M and W never stall.

Hazard terms. Each term applies only when the named slot is valid and `d_valid`=1 where D fields are used.
- LU (load/use):
  - SE.icode is 4'h5 (mrmovq) or 4'hB (popq).
  - SE.dstM is not 4'hF.
  - SE.dstM equals `d_srcA` or `d_srcB`.
- RET: `d_icode`, SE.icode or SM.icode equals 4'h9.
- MP (mispredict): SE.icode is 4'h7 and `e_cnd`=0. Taken branches are predicted, so MP means not-taken.

Output equations (combinational from the shadow slots and D inputs):
- `f_stall` = LU | RET
- `d_stall` = LU
- `d_bubble` = MP | (RET & ~LU)
- `e_bubble` = MP | LU
- `ret_pending` = RET

Rules:
- LU together with RET gives stall, not bubble, in D. The load completes first; the `ret` then drains.
- MP overrides stalls in D: if MP=1, `d_stall` is still LU, but LU cannot coexist with MP because SE holds only one instruction. The implementation asserts this exclusivity in simulation.
- Counters:
  - `stall_cnt` increments by 1 each cycle `f_stall`=1.
  - `bubble_cnt` increments by 1 each cycle `d_bubble`|`e_bubble`=1.
  - Both saturate at 2^CNT_W−1 and never wrap.

Reset (`rst_n`=0, asynchronous):
- All slot valids are cleared.
- Both counters are cleared.
- All five control outputs are forced to 0 while `rst_n`=0, regardless of D inputs.
- Asserting reset mid-operation discards in-flight shadow state immediately.

## Timing
- Control outputs are combinational within the cycle from the registered slots and the current D inputs. There are zero cycles of latency to the pipeline registers, which sample them at the next edge.
- Load/use costs exactly 1 stall cycle. After the edge, the load is in SM, so LU clears.
- `ret` entering D:
  - `f_stall`=1 and `d_bubble`=1 for 3 consecutive cycles: the `ret` in D, then in SE, then in SM.
  - The controls drop in the cycle the `ret` reaches SW.
- Mispredict: 1 cycle of `d_bubble`=`e_bubble`=1, which squashes 2 instructions.
- Counters update at the same edge that the corresponding controls are sampled. The value is visible in the following cycle.
- First edge after `rst_n` rises: slots load normally.

## Test plan
- Load/use:
  - Stimulus: mrmovq with dstM=4'h3 (icode 5) enters SE while D holds addq with srcA=4'h3 (icode 6).
  - Required response: `f_stall`=`d_stall`=`e_bubble`=1 for exactly 1 cycle, `d_bubble`=0.
  - Next cycle: all controls 0 and `stall_cnt`=1.
- ret drain:
  - Stimulus: `d_icode`=9 for 1 cycle, then D is bubbled.
  - Required response: `f_stall`=`d_bubble`=`ret_pending`=1 for 3 cycles, then 0.
  - After the sequence: `stall_cnt`=3 and `bubble_cnt`=3.
- Mispredict:
  - Stimulus: SE holds jne (icode 7) with `e_cnd`=0.
  - Required response: `d_bubble`=`e_bubble`=1 for 1 cycle, `f_stall`=0.
  - Next cycle: SE.valid=0.
  - Variant: repeat with `e_cnd`=1 and check all controls are 0.
- Combined load/use and ret:
  - Stimulus: popq with dstM=4'h4 in SE and `d_icode`=9 with `d_srcA`=4'h4.
  - Required response: `f_stall`=`d_stall`=`e_bubble`=1 and `d_bubble`=0.
  - Next cycle: the RET-only pattern (`f_stall`=`d_bubble`=1).
- No-register source:
  - Stimulus: mrmovq with dstM=4'hF in SE and `d_srcA`=4'hF.
  - Required response: no stall.
- Reset and saturation:
  - Stimulus: with CNT_W=4, hold RET for 20 cycles.
  - Required response: `stall_cnt` saturates at 15.
  - Then pulse `rst_n` low mid-sequence and check that the counters read 0 and all controls read 0 immediately, without waiting for a clock edge.
